ecc_secded_pipe: RTL and testbench
==================================

// Module: ecc_secded_pipe
// PURPOSE
//   Parametrised, pipelined SECDED (extended Hamming) decoder with a combinational encoder.
//   Sits on FIFO read/write paths in sync_aggr and generalises the fixed 30-bit ECC.
//   Stream in with valid/ready, correct single-bit errors, flag double-bit errors.
//   Saturating error counters and a first-error syndrome log for scrubbing/status.
// PARAMETERS
//   DATA_WIDTH    30  protected data bits; must be <= 2**(PARITY_WIDTH-1)-PARITY_WIDTH
//   PARITY_WIDTH  7   check bits incl. overall parity bit p[PARITY_WIDTH-1]
//   CNT_WIDTH     16  width of each saturating error counter
// PORTS
//   clk          in   1    clock, all state on rising edge
//   rst          in   1    synchronous reset, active-high
//   enc_data     in   DW   data to encode (combinational path)
//   enc_parity   out  PW   check bits for enc_data
//   in_valid     in   1    decode input valid
//   in_ready     out  1    decode input ready
//   in_data      in   DW   received data
//   in_parity    in   PW   received check bits
//   bypass       in   1    sampled with input beat: no correction, no flags, no counting
//   out_valid    out  1    decoded beat valid
//   out_ready    in   1    downstream ready
//   out_data     out  DW   corrected data
//   out_sbit_err out  1    beat had a corrected single-bit error (data, check or overall bit)
//   out_dbit_err out  1    beat had an uncorrectable error
//   cnt_clr      in   1    clear both counters and the log
//   sbit_cnt     out  CW   single-error count, saturating at all-ones
//   dbit_cnt     out  CW   double-error count, saturating at all-ones
//   log_vld      out  1    first-error log holds an entry
//   log_syndrome out  PW   {overall, syndrome} of first error since clear
// BEHAVIOUR
//   Column map: data bit i -> pos(i) = i-th integer >= 3 not a power of two (3,5,6,7,9,...).
//   p[k], k<PW-1: XOR of d[i] with bit k of pos(i) set.
//   p[PW-1]: XOR of all d and p[0..PW-2].
//   Decode: s = recomputed low check bits ^ received low check bits; ov = XOR of all received bits.
//     s==0, ov==0       -> clean.
//     ov==1, s==0       -> overall-bit error; sbit, data unchanged.
//     ov==1, s==2^k     -> check-bit error; sbit, data unchanged.
//     ov==1, s==pos(i)  -> flip d[i]; sbit.
//     ov==1, s has no column, or ov==0 with s!=0 -> dbit, data passed uncorrected.
//   Pipeline: S1 registers data, syndrome and ov. S2 registers corrected data and flags.
//   Latency is 2 cycles from accepted input to out_valid with no stall.
//   Stage n loads when it is empty or its contents advance this cycle.
//   in_ready = ~S1.v | S1 advances. Full throughput: 1 beat/cycle.
//   Stalls hold all out_* stable while out_valid & ~out_ready.
//   Counters and log update when an S2 beat is accepted (out_valid & out_ready).
//   Counters saturate at {CW{1'b1}}. An sbit and a dbit never coincide on one beat.
//   Log captures only while log_vld==0.
//   cnt_clr has priority over a same-cycle increment or capture: result is 0, log_vld=0.
//   Reset: S1/S2 valid=0, out_valid=0, out_data=0, flags=0, counters=0, log_vld=0,
//   log_syndrome=0, in_ready=1 in the cycle after rst deasserts.
//   Reset mid-stream drops all in-flight beats. No beat emerges after reset.
// CONFIGURATION
//   ECC_ERR_INJECT_EN defined: adds ports inj_en (in 1) and inj_mask (in DW+PW).
//     When inj_en=1, {in_parity,in_data} is XORed with inj_mask before S1 on accepted beats.
//   ECC_ERR_INJECT_EN undefined: the ports are absent and the datapath is unchanged.
// TESTING
//   1. in_data=0, in_parity=0 -> out_data=0 after 2 clk, sbit=dbit=0, counters stay 0.
//   2. enc_data=30'h1 -> enc_parity=7'b1000011.
//      enc_data=30'h2 -> enc_parity=7'b1000101.
//   3. Encode 30'h2AAAAAAA, flip d[17] -> out_data=30'h2AAAAAAA, sbit=1, sbit_cnt=1, log_vld=1.
//   4. Flip d[3] and d[20] -> dbit=1, data uncorrected, dbit_cnt=1.
//      Flip the overall bit -> sbit=1, data intact.
//   5. 8 back-to-back beats, out_ready low for cycles 3-5 -> all 8 delivered in order,
//      none dropped or duplicated, outputs held during stall.
//   6. Preload sbit_cnt to 16'hFFFE, 3 sbit beats -> saturates at FFFF.
//      cnt_clr on the same cycle as an error -> 0, log_vld=0.
//      Assert rst mid-burst -> out_valid=0 next cycle, no stale beat.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: parametrised SECDED (extended Hamming) codec.
//   - Combinational encoder: enc_data -> enc_parity.
//   - Two-stage decoder with valid/ready handshake and 1 beat/cycle throughput.
//     S1 registers data, syndrome and overall parity. S2 registers corrected data and flags.
//   - Saturating single/double error counters and a first-error syndrome log.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   enc_data / enc_parity         encoder input / check bits
//   in_valid, in_ready            decode input handshake
//   in_data, in_parity, bypass    received word; bypass skips correction, flags and counting
//   out_valid, out_ready          decode output handshake
//   out_data                      corrected data
//   out_sbit_err, out_dbit_err    corrected single error / uncorrectable error
//   cnt_clr                       clears counters and log (wins over a same-cycle update)
//   sbit_cnt, dbit_cnt            saturating error counters
//   log_vld, log_syndrome         first error since clear, as {overall, syndrome}
//
// Optional build macro ECC_ERR_INJECT_EN adds inj_en / inj_mask: when inj_en is high the
// received {in_parity, in_data} is XORed with inj_mask before it enters S1.
//
// DATA_WIDTH must not exceed 2**(PARITY_WIDTH-1) - PARITY_WIDTH.
module ecc_secded_pipe #(
  parameter int unsigned DATA_WIDTH   = 30,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                enc_data,
  output logic [PARITY_WIDTH-1:0]              enc_parity,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [PARITY_WIDTH-1:0]              in_parity,
  input  logic                                 bypass,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_sbit_err,
  output logic                                 out_dbit_err,
  input  logic                                 cnt_clr,
`ifdef ECC_ERR_INJECT_EN
  input  logic                                 inj_en,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   inj_mask,
`endif
  output logic [CNT_WIDTH-1:0]                 sbit_cnt,
  output logic [CNT_WIDTH-1:0]                 dbit_cnt,
  output logic                                 log_vld,
  output logic [PARITY_WIDTH-1:0]              log_syndrome
);

  localparam int unsigned SW = PARITY_WIDTH - 1;  // syndrome width (low check bits)

  typedef logic [DATA_WIDTH-1:0][SW-1:0] col_map_t;

  // Column of data bit i: the i-th integer >= 3 that is not a power of two.
  function automatic col_map_t gen_col_pos();
    col_map_t    m = '0;
    int unsigned n = 0;
    for (int unsigned v = 3; v < (32'd1 << SW); v++) begin
      if (((v & (v - 1)) != 0) && (n < DATA_WIDTH)) begin
        m[n] = v[SW-1:0];
        n++;
      end
    end
    return m;
  endfunction

  localparam col_map_t ColPos = gen_col_pos();

  // Low check bits are the XOR of the columns of all set data bits.
  function automatic logic [SW-1:0] calc_low(input logic [DATA_WIDTH-1:0] d);
    logic [SW-1:0] p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) p = p ^ ColPos[i];
    end
    return p;
  endfunction

  // Encoder
  logic [SW-1:0] enc_low;
  assign enc_low    = calc_low(enc_data);
  assign enc_parity = {^{enc_data, enc_low}, enc_low};

  // Received word, optionally corrupted for error injection
  logic [DATA_WIDTH-1:0]   rx_data;
  logic [PARITY_WIDTH-1:0] rx_parity;
`ifdef ECC_ERR_INJECT_EN
  assign {rx_parity, rx_data} = {in_parity, in_data} ^ (inj_en ? inj_mask : '0);
`else
  assign rx_data   = in_data;
  assign rx_parity = in_parity;
`endif

  // Pipeline state
  logic                    s1_v_q, s2_v_q;
  logic [DATA_WIDTH-1:0]   s1_data_q, s2_data_q;
  logic [SW-1:0]           s1_syn_q;
  logic                    s1_ov_q, s1_byp_q;
  logic                    s2_sbit_q, s2_dbit_q;
  logic [PARITY_WIDTH-1:0] s2_syn_q;

  // Handshake: a stage loads when empty or when its contents leave this cycle
  logic s2_en, out_fire;
  assign out_fire = s2_v_q & out_ready;
  assign s2_en    = ~s2_v_q | out_ready;
  assign in_ready = ~s1_v_q | s2_en;

  // S2 correction
  logic [DATA_WIDTH-1:0] flip_mask, corr_data;
  logic                  corr_sbit, corr_dbit;

  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      flip_mask[i] = (s1_syn_q == ColPos[i]);
    end
    corr_data = s1_data_q;
    corr_sbit = 1'b0;
    corr_dbit = 1'b0;
    if (!s1_byp_q) begin
      if (s1_ov_q) begin
        if ((s1_syn_q == '0) || $onehot(s1_syn_q)) begin
          // Overall or check bit hit: data already good
          corr_sbit = 1'b1;
        end else if (|flip_mask) begin
          corr_data = s1_data_q ^ flip_mask;
          corr_sbit = 1'b1;
        end else begin
          corr_dbit = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        corr_dbit = 1'b1;
      end
    end
  end

  // Counters and log
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic                    log_vld_q, log_vld_d;
  logic [PARITY_WIDTH-1:0] log_syn_q, log_syn_d;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    sbit_cnt_d = sbit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    log_vld_d  = log_vld_q;
    log_syn_d  = log_syn_q;
    if (cnt_clr) begin
      sbit_cnt_d = '0;
      dbit_cnt_d = '0;
      log_vld_d  = 1'b0;
      log_syn_d  = '0;
    end else if (out_fire) begin
      if (s2_sbit_q && (sbit_cnt_q != '1)) sbit_cnt_d = sbit_cnt_q + CntOne;
      if (s2_dbit_q && (dbit_cnt_q != '1)) dbit_cnt_d = dbit_cnt_q + CntOne;
      if (!log_vld_q && (s2_sbit_q || s2_dbit_q)) begin
        log_vld_d = 1'b1;
        log_syn_d = s2_syn_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_ov_q    <= 1'b0;
      s1_byp_q   <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      s2_sbit_q  <= 1'b0;
      s2_dbit_q  <= 1'b0;
      s2_syn_q   <= '0;
      sbit_cnt_q <= '0;
      dbit_cnt_q <= '0;
      log_vld_q  <= 1'b0;
      log_syn_q  <= '0;
    end else begin
      if (in_ready) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= rx_data;
          s1_syn_q  <= calc_low(rx_data) ^ rx_parity[SW-1:0];
          s1_ov_q   <= ^{rx_parity, rx_data};
          s1_byp_q  <= bypass;
        end
      end
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_data_q <= corr_data;
          s2_sbit_q <= corr_sbit;
          s2_dbit_q <= corr_dbit;
          s2_syn_q  <= {s1_ov_q, s1_syn_q};
        end
      end
      sbit_cnt_q <= sbit_cnt_d;
      dbit_cnt_q <= dbit_cnt_d;
      log_vld_q  <= log_vld_d;
      log_syn_q  <= log_syn_d;
    end
  end

  assign out_valid    = s2_v_q;
  assign out_data     = s2_data_q;
  assign out_sbit_err = s2_sbit_q;
  assign out_dbit_err = s2_dbit_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign log_vld      = log_vld_q;
  assign log_syndrome = log_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe (default 30/7/16 configuration).
module tb_ecc_secded_pipe;

  localparam int DW = 30;
  localparam int PW = 7;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] enc_data;
  logic [PW-1:0] enc_parity;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_parity;
  logic          bypass;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_sbit_err, out_dbit_err;
  logic          cnt_clr;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic          log_vld;
  logic [PW-1:0] log_syndrome;
`ifdef ECC_ERR_INJECT_EN
  logic          inj_en = 1'b0;
  logic [DW+PW-1:0] inj_mask = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ecc_secded_pipe #(
    .DATA_WIDTH  (DW),
    .PARITY_WIDTH(PW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_data    (enc_data),
    .enc_parity  (enc_parity),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_parity   (in_parity),
    .bypass      (bypass),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sbit_err(out_sbit_err),
    .out_dbit_err(out_dbit_err),
    .cnt_clr     (cnt_clr),
`ifdef ECC_ERR_INJECT_EN
    .inj_en      (inj_en),
    .inj_mask    (inj_mask),
`endif
    .sbit_cnt    (sbit_cnt),
    .dbit_cnt    (dbit_cnt),
    .log_vld     (log_vld),
    .log_syndrome(log_syndrome)
  );

  // Reference encoder: walk columns 3,5,6,7,9,... skipping powers of two.
  function automatic logic [PW-1:0] model_enc(input logic [DW-1:0] d);
    logic [PW-1:0] p = '0;
    int            pos = 2;
    for (int i = 0; i < DW; i++) begin
      pos++;
      if ((pos & (pos - 1)) == 0) pos++;
      for (int k = 0; k < PW - 1; k++) begin
        if (pos[k]) p[k] = p[k] ^ d[i];
      end
    end
    p[PW-1] = (^d) ^ (^p[PW-2:0]);
    return p;
  endfunction

  localparam logic [DW-1:0] Word = 30'h2AAAAAAA;
  localparam logic [DW-1:0] Bit17 = 30'h0002_0000;

  // Drive one beat into an idle pipe, collect it, and let the counters settle.
  task automatic run_beat(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp,
                          output logic [DW-1:0] od, output logic osb, output logic odb,
                          output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    bypass    = byp;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bypass   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    od  = out_data;
    osb = out_sbit_err;
    odb = out_dbit_err;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_parity = '0;
    bypass    = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    enc_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      miscompares++;
    end
    vectors++;
    if (out_data !== '0 || out_sbit_err !== 1'b0 || out_dbit_err !== 1'b0) begin
      $display("FAIL reset_out: data=%h sbit=%b dbit=%b, want 0 0 0", out_data, out_sbit_err,
               out_dbit_err);
      miscompares++;
    end
    vectors++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0 || log_vld !== 1'b0 || log_syndrome !== '0) begin
      $display("FAIL reset_stat: sbit_cnt=%h dbit_cnt=%h log_vld=%b log_syn=%b, want all 0",
               sbit_cnt, dbit_cnt, log_vld, log_syndrome);
      miscompares++;
    end
  endtask

  task automatic test_encode();
    logic [PW-1:0] exp [4];
    logic [DW-1:0] din [4];
    din = '{30'h1, 30'h2, 30'h0, Word};
    exp = '{7'b1000011, 7'b1000101, 7'b0000000, model_enc(Word)};
    for (int i = 0; i < 4; i++) begin
      enc_data = din[i];
      #1;
      vectors++;
      if (enc_parity !== exp[i]) begin
        $display("FAIL encode[%0d]: data=%h parity=%b, want %b", i, din[i], enc_parity, exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_clean();
    logic [DW-1:0] od;
    logic          sb, db;
    int            lat;
    run_beat('0, '0, 1'b0, od, sb, db, lat);
    vectors++;
    if (lat !== 2) begin
      $display("FAIL clean_latency: %0d cycles, want 2", lat);
      miscompares++;
    end
    vectors++;
    if (od !== '0 || sb !== 1'b0 || db !== 1'b0) begin
      $display("FAIL clean_out: data=%h sbit=%b dbit=%b, want 0 0 0", od, sb, db);
      miscompares++;
    end
    vectors++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0 || log_vld !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL clean_stat: sbit_cnt=%h dbit_cnt=%h log_vld=%b out_valid=%b, want 0",
               sbit_cnt, dbit_cnt, log_vld, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_errors();
    logic [PW-1:0] p;
    logic [DW-1:0] od;
    logic          sb, db;
    int            lat;
    p = model_enc(Word);

    // d[17] -> syndrome 23, logged as {1, 010111}
    run_beat(Word ^ Bit17, p, 1'b0, od, sb, db, lat);
    vectors++;
    if (od !== Word || sb !== 1'b1 || db !== 1'b0) begin
      $display("FAIL single_d17: data=%h sbit=%b dbit=%b, want %h 1 0", od, sb, db, Word);
      miscompares++;
    end
    vectors++;
    if (sbit_cnt !== 16'd1 || log_vld !== 1'b1 || log_syndrome !== 7'b1010111) begin
      $display("FAIL single_stat: sbit_cnt=%h log_vld=%b log_syn=%b, want 1 1 1010111",
               sbit_cnt, log_vld, log_syndrome);
      miscompares++;
    end

    // d[3] and d[20]: syndrome 29 with even parity -> uncorrectable
    run_beat(Word ^ 30'h0010_0008, p, 1'b0, od, sb, db, lat);
    vectors++;
    if (od !== (Word ^ 30'h0010_0008) || sb !== 1'b0 || db !== 1'b1) begin
      $display("FAIL double_d3_d20: data=%h sbit=%b dbit=%b, want %h 0 1", od, sb, db,
               Word ^ 30'h0010_0008);
      miscompares++;
    end
    vectors++;
    if (dbit_cnt !== 16'd1 || sbit_cnt !== 16'd1 || log_syndrome !== 7'b1010111) begin
      $display("FAIL double_stat: dbit_cnt=%h sbit_cnt=%h log_syn=%b, want 1 1 1010111",
               dbit_cnt, sbit_cnt, log_syndrome);
      miscompares++;
    end

    // Overall parity bit only
    run_beat(Word, p ^ 7'h40, 1'b0, od, sb, db, lat);
    vectors++;
    if (od !== Word || sb !== 1'b1 || db !== 1'b0 || sbit_cnt !== 16'd2) begin
      $display("FAIL overall_bit: data=%h sbit=%b dbit=%b cnt=%h, want %h 1 0 2", od, sb, db,
               sbit_cnt, Word);
      miscompares++;
    end

    // Check bit p[2]
    run_beat(Word, p ^ 7'h04, 1'b0, od, sb, db, lat);
    vectors++;
    if (od !== Word || sb !== 1'b1 || db !== 1'b0 || sbit_cnt !== 16'd3) begin
      $display("FAIL check_bit: data=%h sbit=%b dbit=%b cnt=%h, want %h 1 0 3", od, sb, db,
               sbit_cnt, Word);
      miscompares++;
    end

    // d[27..29]: syndrome 37 with odd parity, no such column -> uncorrectable
    run_beat(Word ^ 30'h3800_0000, p, 1'b0, od, sb, db, lat);
    vectors++;
    if (od !== (Word ^ 30'h3800_0000) || sb !== 1'b0 || db !== 1'b1 || dbit_cnt !== 16'd2) begin
      $display("FAIL no_column: data=%h sbit=%b dbit=%b cnt=%h, want %h 0 1 2", od, sb, db,
               dbit_cnt, Word ^ 30'h3800_0000);
      miscompares++;
    end

    // Bypass: error passes through untouched and uncounted
    run_beat(Word ^ Bit17, p, 1'b1, od, sb, db, lat);
    vectors++;
    if (od !== (Word ^ Bit17) || sb !== 1'b0 || db !== 1'b0 || sbit_cnt !== 16'd3 ||
        dbit_cnt !== 16'd2) begin
      $display("FAIL bypass: data=%h sbit=%b dbit=%b cnts=%h/%h, want %h 0 0 3/2", od, sb, db,
               sbit_cnt, dbit_cnt, Word ^ Bit17);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [8];
    logic [DW-1:0] held;
    logic          stalled;
    int            sent, got;
    words = '{30'h0000001, 30'h3FFFFFFF, 30'h15555555, 30'h2AAAAAAA,
              30'h00F0F0F0, 30'h03C3C3C3, 30'h01234567, 30'h00FEDCBA};
    sent = 0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data   = words[sent];
        in_parity = model_enc(words[sent]);
      end
      #1;
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          $display("FAIL stall_hold: valid=%b data=%h, want 1 %h", out_valid, out_data, held);
          miscompares++;
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        vectors++;
        if (out_data !== words[got] || out_sbit_err !== 1'b0 || out_dbit_err !== 1'b0) begin
          $display("FAIL b2b_beat[%0d]: data=%h flags=%b%b, want %h 00", got, out_data,
                   out_sbit_err, out_dbit_err, words[got]);
          miscompares++;
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 8) begin
      $display("FAIL b2b_count: %0d beats delivered, want 8", got);
      miscompares++;
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        $display("FAIL b2b_extra: out_valid=%b after burst, want 0", out_valid);
        miscompares++;
      end
    end
  endtask

  task automatic test_saturate_clear();
    logic [PW-1:0] p;
    logic [DW-1:0] od;
    logic          sb, db;
    int            lat, w;
    p = model_enc(Word);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    vectors++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0 || log_vld !== 1'b0) begin
      $display("FAIL clear: sbit_cnt=%h dbit_cnt=%h log_vld=%b, want 0 0 0", sbit_cnt,
               dbit_cnt, log_vld);
      miscompares++;
    end

    // Bring the single-error count up to FFFE
    in_valid  = 1'b1;
    in_data   = Word ^ Bit17;
    in_parity = p;
    out_ready = 1'b1;
    repeat (65534) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sbit_cnt !== 16'hFFFE) begin
      $display("FAIL preload: sbit_cnt=%h, want fffe", sbit_cnt);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      run_beat(Word ^ Bit17, p, 1'b0, od, sb, db, lat);
      vectors++;
      if (sbit_cnt !== 16'hFFFF || sb !== 1'b1 || od !== Word) begin
        $display("FAIL saturate[%0d]: sbit_cnt=%h sbit=%b data=%h, want ffff 1 %h", i,
                 sbit_cnt, sb, od, Word);
        miscompares++;
      end
    end

    // Clear on the same cycle an error beat is accepted
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = Word ^ 30'h0010_0008;
    in_parity = p;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    vectors++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0 || log_vld !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL clear_collide: sbit=%h dbit=%h log_vld=%b out_valid=%b, want 0 0 0 0",
               sbit_cnt, dbit_cnt, log_vld, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = Word ^ Bit17;
    in_parity = model_enc(Word);
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      $display("FAIL mid_busy: out_valid=%b before reset, want 1", out_valid);
      miscompares++;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL mid_flush: out_valid=%b after reset edge, want 0", out_valid);
      miscompares++;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || sbit_cnt !== '0 || log_vld !== 1'b0) begin
      $display("FAIL mid_state: in_ready=%b sbit_cnt=%h log_vld=%b, want 1 0 0", in_ready,
               sbit_cnt, log_vld);
      miscompares++;
    end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        $display("FAIL mid_stale: out_valid=%b after reset, want 0", out_valid);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_clean();
    test_errors();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
